// File: rtl/maxpool_pe_if.sv
// Pixel stream into the pooling stage and pooled stream out of it.
// The master drives conv pixels and the slave (maxpool_pe) returns pooled values.
interface maxpool_pe_if #(
  parameter int dwidth = 16
);
  logic                     din_valid;
  logic                     din_start;
  logic signed [dwidth-1:0] din;
  logic signed [dwidth-1:0] dout;
  logic                     dout_valid;
  logic                     frame_done;

  modport master (
    output din_valid, din_start, din,
    input  dout, dout_valid, frame_done
  );

  modport slave (
    input  din_valid, din_start, din,
    output dout, dout_valid, frame_done
  );
endinterface

// File: rtl/maxpool_pe.sv
// Optional ReLU followed by 2x2 stride-2 max pooling on a row-major conv output stream.
// One half-row line buffer keeps the pair maxima of each even row until the odd row below arrives.
module maxpool_pe #(
  parameter int dwidth = 16,
  parameter int MAX_W  = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] featmap_size,
  input  logic       relu_en,
  maxpool_pe_if.slave bus
);
  localparam int LB_DEPTH = MAX_W / 2;
  localparam int AW       = $clog2(LB_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;
  logic [4:0] col_q, col_d, row_q, row_d, w_q, w_d;
  logic relu_q, relu_d;
  logic signed [dwidth-1:0] hold_q, hold_d, rd_q, rd_d, dout_q, dout_d;
  logic dout_valid_q, dout_valid_d, frame_done_q, frame_done_d;

  logic signed [dwidth-1:0] linebuf_mem [LB_DEPTH];
  logic                     lb_we;
  logic [AW-1:0]            lb_addr;
  logic signed [dwidth-1:0] lb_wdata;

  logic accept, start;
  logic [4:0] w_eff, w_cfg, w_even, pc, pr;
  logic relu_eff, in_win, last;
  logic signed [dwidth-1:0] x_relu, pair, quad;

  // A start pulse overrides the running position and configuration in the same cycle.
  always_comb begin
    w_cfg = featmap_size;
    if (featmap_size < 5'd2)
      w_cfg = 5'd2;
    else if (featmap_size > 5'(MAX_W))
      w_cfg = 5'(MAX_W);
  end

  assign start    = bus.din_valid && bus.din_start;
  assign accept   = start || (bus.din_valid && state_q == RUN);
  assign w_eff    = start ? w_cfg   : w_q;
  assign relu_eff = start ? relu_en : relu_q;
  assign pc       = start ? 5'd0    : col_q;
  assign pr       = start ? 5'd0    : row_q;
  assign w_even   = {w_eff[4:1], 1'b0};
  assign in_win   = (pc < w_even) && (pr < w_even);
  assign last     = (pc == w_eff - 5'd1) && (pr == w_eff - 5'd1);
  assign x_relu   = (relu_eff && bus.din[dwidth-1]) ? '0 : bus.din;
  assign pair     = (x_relu > hold_q) ? x_relu : hold_q;
  assign quad     = (rd_q > pair) ? rd_q : pair;
  assign lb_addr  = AW'(pc >> 1);
  assign lb_wdata = pair;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)
      state_d = last ? IDLE : RUN;
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    w_d          = w_q;
    relu_d       = relu_q;
    hold_d       = hold_q;
    rd_d         = rd_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    if (accept) begin
      w_d    = w_eff;
      relu_d = relu_eff;
      if (last) begin
        col_d        = 5'd0;
        row_d        = 5'd0;
        frame_done_d = 1'b1;
      end else if (pc == w_eff - 5'd1) begin
        col_d = 5'd0;
        row_d = pr + 5'd1;
      end else begin
        col_d = pc + 5'd1;
        row_d = pr;
      end
      // Odd rows fetch the stored pair on the even column so the read is registered.
      if (in_win) begin
        if (!pc[0]) begin
          hold_d = x_relu;
          if (pr[0])
            rd_d = linebuf_mem[lb_addr];
        end else if (!pr[0]) begin
          lb_we = 1'b1;
        end else begin
          dout_d       = quad;
          dout_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we)
      linebuf_mem[lb_addr] <= lb_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      w_q          <= 5'd2;
      relu_q       <= 1'b0;
      hold_q       <= '0;
      rd_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      w_q          <= w_d;
      relu_q       <= relu_d;
      hold_q       <= hold_d;
      rd_q         <= rd_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_maxpool_pe.sv
// Directed bench for maxpool_pe: ramps, negative data, odd width, bubbles, restart and async reset.
`timescale 1ns/1ps
module tb_maxpool_pe;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] featmap_size = 5'd4;
  logic       relu_en = 1'b0;

  maxpool_pe_if #(.dwidth(16)) bus();

  maxpool_pe #(.dwidth(16), .MAX_W(28)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .featmap_size (featmap_size),
    .relu_en      (relu_en),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic signed [15:0] outq[$];
  int fd_cnt = 0;
  int fd_with_dv = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dout_valid) begin
        outq.push_back(bus.dout);
        $display("out: dout=%0d frame_done=%0b", bus.dout, bus.frame_done);
      end
      if (bus.frame_done) begin
        fd_cnt++;
        if (bus.dout_valid) fd_with_dv++;
        else $display("out: frame_done alone");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic signed [15:0] v, input logic st, input int bubbles);
    repeat (bubbles) begin
      @(posedge clk); #1;
      bus.din_valid = 1'b0;
      bus.din_start = 1'b0;
    end
    @(posedge clk); #1;
    bus.din_valid = 1'b1;
    bus.din_start = st;
    bus.din       = v;
  endtask

  task automatic idle_bus();
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    bus.din_start = 1'b0;
  endtask

  // Pixel i of the frame carries base + step*i; bub!=0 inserts 1..3 idle cycles before each pixel.
  task automatic run_frame(input int w, input int base, input int step, input bit bub);
    for (int i = 0; i < w * w; i++)
      drive(16'(base + step * i), i == 0, bub ? (i % 3) + 1 : 0);
    idle_bus();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.din_valid = 1'b0;
    bus.din_start = 1'b0;
    bus.din       = '0;
    #12;
    n_total++;
    if (bus.dout !== 16'sd0) $display("FAIL reset_dout: got %0d want 0", bus.dout);
    else n_pass++;
    n_total++;
    if (bus.dout_valid !== 1'b0) $display("FAIL reset_dout_valid: got %b want 0", bus.dout_valid);
    else n_pass++;
    n_total++;
    if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", bus.frame_done);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    // A lone din_valid without start while idle must produce nothing.
    drive(16'sd99, 1'b0, 0);
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (outq.size() !== 0) $display("FAIL idle_ignore: got %0d outputs want 0", outq.size());
    else n_pass++;
  endtask

  task automatic test_relu_ramp();
    int q0, fd0, fdv0;
    int exp_v[4] = '{6, 8, 14, 16};
    q0 = outq.size(); fd0 = fd_cnt; fdv0 = fd_with_dv;
    featmap_size = 5'd4; relu_en = 1'b1;
    run_frame(4, 1, 1, 1'b0);
    n_total++;
    if (outq.size() - q0 !== 4) $display("FAIL ramp_count: got %0d want 4", outq.size() - q0);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (outq[q0 + k] !== 16'(exp_v[k])) $display("FAIL ramp_val%0d: got %0d want %0d", k, outq[q0 + k], exp_v[k]);
      else n_pass++;
    end
    n_total++;
    if (fd_with_dv - fdv0 !== 1 || fd_cnt - fd0 !== 1)
      $display("FAIL ramp_frame_done: got %0d (with dout %0d) want 1 with dout", fd_cnt - fd0, fd_with_dv - fdv0);
    else n_pass++;
  endtask

  task automatic test_negative();
    int q0;
    int exp_v[4] = '{-1, -3, -9, -11};
    for (int r = 0; r < 2; r++) begin
      q0 = outq.size();
      featmap_size = 5'd4; relu_en = (r == 1);
      run_frame(4, -1, -1, 1'b0);
      n_total++;
      if (outq.size() - q0 !== 4) $display("FAIL neg_count_relu%0d: got %0d want 4", r, outq.size() - q0);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_total++;
        if (outq[q0 + k] !== 16'((r == 1) ? 0 : exp_v[k]))
          $display("FAIL neg_val_relu%0d_%0d: got %0d want %0d", r, k, outq[q0 + k], (r == 1) ? 0 : exp_v[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_odd_width();
    int q0, fd0, fdv0;
    q0 = outq.size(); fd0 = fd_cnt; fdv0 = fd_with_dv;
    featmap_size = 5'd3; relu_en = 1'b0;
    for (int i = 0; i < 9; i++) drive(16'(i + 1), i == 0, 0);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.frame_done !== 1'b1 || bus.dout_valid !== 1'b0)
      $display("FAIL odd_frame_done_timing: got fd=%b dv=%b want fd=1 dv=0", bus.frame_done, bus.dout_valid);
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (outq.size() - q0 !== 1) $display("FAIL odd_count: got %0d want 1", outq.size() - q0);
    else n_pass++;
    n_total++;
    if (outq[q0] !== 16'sd5) $display("FAIL odd_val: got %0d want 5", outq[q0]);
    else n_pass++;
    n_total++;
    if (fd_cnt - fd0 !== 1 || fd_with_dv - fdv0 !== 0)
      $display("FAIL odd_frame_done_count: got %0d (with dout %0d) want 1 alone", fd_cnt - fd0, fd_with_dv - fdv0);
    else n_pass++;
  endtask

  task automatic test_bubbles();
    int q0, fd0;
    int exp_v[4] = '{6, 8, 14, 16};
    q0 = outq.size(); fd0 = fd_cnt;
    featmap_size = 5'd4; relu_en = 1'b1;
    run_frame(4, 1, 1, 1'b1);
    n_total++;
    if (outq.size() - q0 !== 4) $display("FAIL bubble_count: got %0d want 4", outq.size() - q0);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (outq[q0 + k] !== 16'(exp_v[k])) $display("FAIL bubble_val%0d: got %0d want %0d", k, outq[q0 + k], exp_v[k]);
      else n_pass++;
    end
    n_total++;
    if (fd_cnt - fd0 !== 1) $display("FAIL bubble_frame_done: got %0d want 1", fd_cnt - fd0);
    else n_pass++;
  endtask

  task automatic test_restart();
    int q0, fd0;
    // Pixel 6 sits at (1,1) and closes the first window, so the aborted frame leaves one 6 behind.
    int exp_v[5] = '{6, 6, 8, 14, 16};
    q0 = outq.size(); fd0 = fd_cnt;
    featmap_size = 5'd4; relu_en = 1'b0;
    for (int i = 0; i < 6; i++) drive(16'(i + 1), i == 0, 0);
    run_frame(4, 1, 1, 1'b0);
    n_total++;
    if (outq.size() - q0 !== 5) $display("FAIL restart_count: got %0d want 5", outq.size() - q0);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if (outq[q0 + k] !== 16'(exp_v[k])) $display("FAIL restart_val%0d: got %0d want %0d", k, outq[q0 + k], exp_v[k]);
      else n_pass++;
    end
    n_total++;
    if (fd_cnt - fd0 !== 1) $display("FAIL restart_frame_done: got %0d want 1", fd_cnt - fd0);
    else n_pass++;
  endtask

  task automatic test_min_size();
    int q0, fd0, fdv0;
    q0 = outq.size(); fd0 = fd_cnt; fdv0 = fd_with_dv;
    featmap_size = 5'd1; relu_en = 1'b0;
    drive(16'sd3, 1'b1, 0);
    drive(16'sd7, 1'b0, 0);
    drive(-16'sd2, 1'b0, 0);
    drive(16'sd5, 1'b0, 0);
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (outq.size() - q0 !== 1 || outq[q0] !== 16'sd7)
      $display("FAIL min_size_val: got %0d outputs first %0d want 1 output 7", outq.size() - q0, outq[q0]);
    else n_pass++;
    n_total++;
    if (fd_cnt - fd0 !== 1 || fd_with_dv - fdv0 !== 1)
      $display("FAIL min_size_frame_done: got %0d (with dout %0d) want 1 with dout", fd_cnt - fd0, fd_with_dv - fdv0);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int q0;
    int exp_v[4] = '{6, 8, 14, 16};
    featmap_size = 5'd4; relu_en = 1'b1;
    for (int i = 0; i < 6; i++) drive(16'(i + 1), i == 0, 0);
    @(posedge clk); #3;
    n_total++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 16'sd6)
      $display("FAIL arst_pre: got dv=%b dout=%0d want dv=1 dout=6", bus.dout_valid, bus.dout);
    else n_pass++;
    rst_n = 1'b0;
    bus.din_valid = 1'b0;
    bus.din_start = 1'b0;
    #1;
    n_total++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== 16'sd0 || bus.frame_done !== 1'b0)
      $display("FAIL arst_drop: got dv=%b dout=%0d fd=%b want all 0", bus.dout_valid, bus.dout, bus.frame_done);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    q0 = outq.size();
    run_frame(4, 1, 1, 1'b0);
    n_total++;
    if (outq.size() - q0 !== 4) $display("FAIL arst_after_count: got %0d want 4", outq.size() - q0);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (outq[q0 + k] !== 16'(exp_v[k])) $display("FAIL arst_after_val%0d: got %0d want %0d", k, outq[q0 + k], exp_v[k]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_relu_ramp();
    test_negative();
    test_odd_width();
    test_bubbles();
    test_restart();
    test_min_size();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
